// File: rtl/mop_instr_seq.sv
// ---------------------------------------------------------------------------
// mop_instr_seq
// Small micro-op instruction sequencer. A loader fills a DEPTH-entry table
// through a simple write port. A start request then issues entries in order,
// beginning at entry 0, over a valid/ready handshake. A run ends normally
// when the consumer accepts an entry that carries the LAST marker (top data
// bit) or the final table slot. It ends in error when the next slot was
// never loaded, and an abort request cancels it quietly.
//
// Ports
//   clk_i          : clock, all logic on its rising edge
//   rst_i          : synchronous active-high reset
//   ext_wr         : loader write strobe (ignored while a run is active)
//   ext_addr       : loader write entry index
//   ext_data_in    : loader write data, bit DATA_W-1 is the LAST marker
//   start_i        : begin issuing from entry 0
//   clear_i        : invalidate all loaded entries and clear the error flag
//   abort_i        : cancel an active run
//   instr_o        : instruction presented to the consumer (0 when idle)
//   instr_valid_o  : instr_o is valid (high for the whole run)
//   instr_ready_i  : consumer accepts the presented instruction
//   busy_o         : a run is active
//   done_o         : one-cycle pulse on normal completion
//   err_o          : sticky error flag
//   wr_drop_o      : one-cycle pulse when a loader write was discarded
//   issued_cnt_o   : handshakes completed in the current or last run
// ---------------------------------------------------------------------------
module mop_instr_seq #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 17
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         ext_wr,
   input  logic [$clog2(DEPTH)-1:0]     ext_addr,
   input  logic [DATA_W-1:0]            ext_data_in,
   input  logic                         start_i,
   input  logic                         clear_i,
   input  logic                         abort_i,
   output logic [DATA_W-1:0]            instr_o,
   output logic                         instr_valid_o,
   input  logic                         instr_ready_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         err_o,
   output logic                         wr_drop_o,
   output logic [$clog2(DEPTH+1)-1:0]   issued_cnt_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [AW-1:0]    LAST_PTR = AW'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE,
      S_ERR
   } state_t;

   state_t               state_q, state_d;
   logic [DATA_W-1:0]    mem [DEPTH];
   logic [DEPTH-1:0]     loaded_q, loaded_d;
   logic [AW-1:0]        ptr_q, ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic                 done_q, done_d;
   logic                 drop_q, drop_d;
   logic                 mem_we;

   logic [DATA_W-1:0]    cur_instr;
   logic [AW-1:0]        ptr_nxt;
   logic                 is_last;

   // The entry currently being offered, and whether accepting it ends the
   // run. The table end counts as an implicit LAST marker.
   assign cur_instr = mem[ptr_q];
   assign ptr_nxt   = ptr_q + 1'b1;
   assign is_last   = cur_instr[DATA_W-1] || (ptr_q == LAST_PTR);

   // State register. Reset returns to IDLE; the table contents are not
   // reset, only the loaded bitmap, so stale data can never be issued.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath update decisions. Outside a run, DONE and ERR
   // behave exactly like IDLE. Clear takes precedence over start, so a
   // same-cycle clear/start only clears. A same-cycle write to entry 0
   // counts as loaded when deciding whether a start may run. Inside a run,
   // abort beats a handshake, and loader writes are dropped and flagged.
   always_comb begin
      state_d  = state_q;
      loaded_d = loaded_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      done_d   = 1'b0;
      drop_d   = 1'b0;
      mem_we   = 1'b0;

      if (state_q == S_RUN) begin
         drop_d = ext_wr;
         if (abort_i) begin
            state_d = S_IDLE;
         end else if (instr_ready_i) begin
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (is_last) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (!loaded_q[ptr_nxt]) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else begin
               ptr_d = ptr_nxt;
            end
         end
      end else begin
         mem_we = ext_wr;
         if (clear_i) begin
            loaded_d = '0;
            err_d    = 1'b0;
         end
         if (ext_wr) begin
            loaded_d[ext_addr] = 1'b1;
         end
         if (start_i && !clear_i) begin
            err_d = 1'b0;
            cnt_d = '0;
            ptr_d = '0;
            if (loaded_q[0] || (ext_wr && (ext_addr == '0))) begin
               state_d = S_RUN;
            end else begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end
         end
      end
   end

   // Control registers that travel with the state machine: bitmap, issue
   // pointer, handshake counter and the three status flags.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         loaded_q <= '0;
         ptr_q    <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         loaded_q <= loaded_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         done_q   <= done_d;
         drop_q   <= drop_d;
      end
   end

   // Instruction table. Kept free of reset so it maps onto plain storage;
   // a write that arrives while reset is asserted is discarded.
   always_ff @(posedge clk_i) begin
      if (!rst_i && mem_we) begin
         mem[ext_addr] <= ext_data_in;
      end
   end

   // Consumer-facing outputs. The instruction bus is forced to zero outside
   // a run so the consumer never sees stale table data.
   always_comb begin
      instr_valid_o = 1'b0;
      busy_o        = 1'b0;
      instr_o       = '0;
      if (state_q == S_RUN) begin
         instr_valid_o = 1'b1;
         busy_o        = 1'b1;
         instr_o       = cur_instr;
      end
   end

   assign done_o       = done_q;
   assign err_o        = err_q;
   assign wr_drop_o    = drop_q;
   assign issued_cnt_o = cnt_q;

endmodule
